// File: rtl/sampletest_msaa.sv
// sampletest_msaa: multisample coverage tester for one triangle and one pixel.
// Each accepted pixel is expanded into NSAMP jittered sample positions. The
// samples are evaluated LANES at a time against the three edge functions
// through a PIPE_DEPTH-stage pipeline, and one result beat is returned per
// pixel.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid_R16H / in_ready_R16H    input handshake
//   tri_R16S[VERTS][AXIS]    triangle vertices (signed)
//   color_R16U[COLORS]       triangle color
//   pixel_R16S[2]            pixel base x,y
//   offset_R16S[NSAMP][2]    per-sample jitter offsets
//   out_valid_R18H / out_ready_R18H  output handshake
//   hit_mask_R18H            per-sample inside mask
//   hit_count_R18U           popcount of the mask
//   hit_R18S[AXIS]           pixel x, pixel y, vertex-0 z
//   color_R18U[COLORS]       color of the triangle
//
// Build option: SAMPLETEST_CULL_EN selects backface culling. With it, only
// front-facing samples hit. Without it, both windings hit.
module sampletest_msaa #(
    parameter int unsigned SIGFIG     = 24,
    parameter int unsigned RADIX      = 10,
    parameter int unsigned VERTS      = 3,
    parameter int unsigned AXIS       = 3,
    parameter int unsigned COLORS     = 3,
    parameter int unsigned NSAMP      = 4,
    parameter int unsigned LANES      = 2,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid_R16H,
    output logic                              in_ready_R16H,
    input  logic signed [SIGFIG-1:0]          tri_R16S    [VERTS][AXIS],
    input  logic        [SIGFIG-1:0]          color_R16U  [COLORS],
    input  logic signed [SIGFIG-1:0]          pixel_R16S  [2],
    input  logic signed [SIGFIG-1:0]          offset_R16S [NSAMP][2],
    output logic                              out_valid_R18H,
    input  logic                              out_ready_R18H,
    output logic        [NSAMP-1:0]           hit_mask_R18H,
    output logic        [$clog2(NSAMP+1)-1:0] hit_count_R18U,
    output logic signed [SIGFIG-1:0]          hit_R18S    [AXIS],
    output logic        [SIGFIG-1:0]          color_R18U  [COLORS]
);

    localparam int unsigned NG = NSAMP / LANES;
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned CW = $clog2(NG + 1);
    localparam int unsigned IW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int unsigned DW = 2 * SIGFIG;
    localparam int unsigned MW = $clog2(NSAMP + 1);
    localparam int unsigned NE = 3;

    // Elaboration-time parameter checks
    if (VERTS != 3) begin : g_chk_verts
        $error("sampletest_msaa: VERTS must be 3");
    end
    if (AXIS < 3) begin : g_chk_axis
        $error("sampletest_msaa: AXIS must be at least 3");
    end
    if (LANES == 0 || (NSAMP % LANES) != 0) begin : g_chk_lanes
        $error("sampletest_msaa: NSAMP must be a nonzero multiple of LANES");
    end
    if (PIPE_DEPTH < 1) begin : g_chk_depth
        $error("sampletest_msaa: PIPE_DEPTH must be at least 1");
    end
    if (RADIX >= SIGFIG) begin : g_chk_radix
        $error("sampletest_msaa: RADIX must be smaller than SIGFIG");
    end

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t state, state_next;

    logic signed [SIGFIG-1:0] tri_r [VERTS][AXIS];
    logic        [SIGFIG-1:0] col_r [COLORS];
    logic signed [SIGFIG-1:0] pix_r [2];
    logic signed [SIGFIG-1:0] off_r [NSAMP][2];

    logic [CW-1:0]    g_cnt;
    logic [NSAMP-1:0] mask_acc;
    logic [NSAMP-1:0] mask_next;

    logic                 pv    [PIPE_DEPTH];
    logic [GW-1:0]        pg    [PIPE_DEPTH];
    logic signed [DW-1:0] pdist [PIPE_DEPTH][LANES][NE];

    logic [IW-1:0]            sample_idx [LANES];
    logic signed [SIGFIG-1:0] samp_x     [LANES];
    logic signed [SIGFIG-1:0] samp_y     [LANES];
    logic signed [SIGFIG-1:0] rel_x      [LANES][NE];
    logic signed [SIGFIG-1:0] rel_y      [LANES][NE];
    logic signed [DW-1:0]     issue_dist [LANES][NE];
    logic [LANES-1:0]         lane_hit;

    logic accept;
    logic issue;
    logic last_retire;

    // z of vertices 1 and 2 does not take part in coverage
    logic unused_z;
    assign unused_z = ^{tri_r[1][2], tri_r[2][2]};

    // 2D cross product of the shifted edge endpoints, exact at DW bits
    function automatic logic signed [DW-1:0] cross2(
        input logic signed [SIGFIG-1:0] xa,
        input logic signed [SIGFIG-1:0] ya,
        input logic signed [SIGFIG-1:0] xb,
        input logic signed [SIGFIG-1:0] yb
    );
        return DW'(xa) * DW'(yb) - DW'(ya) * DW'(xb);
    endfunction

    // Coverage rule; strict middle edge keeps degenerate triangles empty
    function automatic logic edge_hit(
        input logic signed [DW-1:0] d0,
        input logic signed [DW-1:0] d1,
        input logic signed [DW-1:0] d2
    );
        logic front;
        logic back;
        front = (d0[DW-1] | (d0 == '0)) & d1[DW-1] & (d2[DW-1] | (d2 == '0));
        back  = ~d0[DW-1] & ~d1[DW-1] & (d1 != '0) & ~d2[DW-1];
`ifdef SAMPLETEST_CULL_EN
        back  = 1'b0;
`endif
        return front | back;
    endfunction

    function automatic logic [MW-1:0] popcount(input logic [NSAMP-1:0] m);
        logic [MW-1:0] c;
        c = '0;
        for (int i = 0; i < NSAMP; i++) begin
            c = c + MW'(m[i]);
        end
        return c;
    endfunction

    assign accept      = in_valid_R16H & in_ready_R16H;
    assign issue       = (state == BUSY) && (g_cnt != CW'(NG));
    assign last_retire = pv[PIPE_DEPTH-1] && (pg[PIPE_DEPTH-1] == GW'(NG - 1));

    // FSM state register; out_valid mirrors the HOLD state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            out_valid_R18H <= 1'b0;
        end else begin
            state          <= state_next;
            out_valid_R18H <= (state_next == HOLD);
        end
    end

    // Next state and input ready; HOLD passes downstream ready straight through
    always_comb begin
        state_next    = state;
        in_ready_R16H = 1'b0;
        case (state)
            IDLE: begin
                in_ready_R16H = 1'b1;
                if (in_valid_R16H) state_next = BUSY;
            end
            BUSY: begin
                if (last_retire) state_next = HOLD;
            end
            HOLD: begin
                in_ready_R16H = out_ready_R18H;
                if (out_ready_R18H) state_next = in_valid_R16H ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Input capture on the accepting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++) tri_r[v][a] <= '0;
            for (int c = 0; c < COLORS; c++) col_r[c] <= '0;
            for (int k = 0; k < 2; k++) pix_r[k] <= '0;
            for (int i = 0; i < NSAMP; i++) begin
                off_r[i][0] <= '0;
                off_r[i][1] <= '0;
            end
        end else if (accept) begin
            tri_r <= tri_R16S;
            col_r <= color_R16U;
            pix_r <= pixel_R16S;
            off_r <= offset_R16S;
        end
    end

    // Group counter and mask accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_cnt    <= '0;
            mask_acc <= '0;
        end else begin
            if (accept)     g_cnt <= '0;
            else if (issue) g_cnt <= g_cnt + CW'(1);
            if (accept)                     mask_acc <= '0;
            else if (pv[PIPE_DEPTH-1])      mask_acc <= mask_next;
        end
    end

    // Edge distances for the group being issued this cycle
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sample_idx[l] = '0;
            samp_x[l]     = '0;
            samp_y[l]     = '0;
            for (int e = 0; e < NE; e++) begin
                rel_x[l][e]      = '0;
                rel_y[l][e]      = '0;
                issue_dist[l][e] = '0;
            end
        end
        if (issue) begin
            for (int l = 0; l < LANES; l++) begin
                sample_idx[l] = IW'(32'(g_cnt) * LANES + 32'(l));
                samp_x[l]     = pix_r[0] + off_r[sample_idx[l]][0];
                samp_y[l]     = pix_r[1] + off_r[sample_idx[l]][1];
                for (int v = 0; v < NE; v++) begin
                    rel_x[l][v] = tri_r[v][0] - samp_x[l];
                    rel_y[l][v] = tri_r[v][1] - samp_y[l];
                end
                issue_dist[l][0] = cross2(rel_x[l][0], rel_y[l][0], rel_x[l][1], rel_y[l][1]);
                issue_dist[l][1] = cross2(rel_x[l][1], rel_y[l][1], rel_x[l][2], rel_y[l][2]);
                issue_dist[l][2] = cross2(rel_x[l][2], rel_y[l][2], rel_x[l][0], rel_y[l][0]);
            end
        end
    end

    // Edge-distance pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pv[k] <= 1'b0;
                pg[k] <= '0;
                for (int l = 0; l < LANES; l++)
                    for (int e = 0; e < NE; e++) pdist[k][l][e] <= '0;
            end
        end else begin
            pv[0] <= issue;
            pg[0] <= GW'(g_cnt);
            for (int l = 0; l < LANES; l++)
                for (int e = 0; e < NE; e++) pdist[0][l][e] <= issue_dist[l][e];
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                pv[k] <= pv[k-1];
                pg[k] <= pg[k-1];
                for (int l = 0; l < LANES; l++)
                    for (int e = 0; e < NE; e++) pdist[k][l][e] <= pdist[k-1][l][e];
            end
        end
    end

    // Retiring group: apply the hit rule and merge into the mask
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_hit[l] = edge_hit(pdist[PIPE_DEPTH-1][l][0],
                                   pdist[PIPE_DEPTH-1][l][1],
                                   pdist[PIPE_DEPTH-1][l][2]);
        end
        mask_next = mask_acc | (NSAMP'(lane_hit) << (32'(pg[PIPE_DEPTH-1]) * LANES));
    end

    // Result registers, loaded when the last group retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_mask_R18H  <= '0;
            hit_count_R18U <= '0;
            for (int a = 0; a < AXIS; a++) hit_R18S[a] <= '0;
            for (int c = 0; c < COLORS; c++) color_R18U[c] <= '0;
        end else if (last_retire) begin
            hit_mask_R18H  <= mask_next;
            hit_count_R18U <= popcount(mask_next);
            hit_R18S[0]    <= pix_r[0];
            hit_R18S[1]    <= pix_r[1];
            hit_R18S[2]    <= tri_r[0][2];
            color_R18U     <= col_r;
        end
    end

endmodule
